// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous data RAM between the CPU (C) and DMA (D) ports.
// Grant one clk after request in IDLE, read data one clk after grant; requesters wait by holding req until gnt.
module dmem_arbiter #(
    parameter int AW = 14,
    parameter int DW = 24,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [CW-1:0] c_count,
    output logic [CW-1:0] d_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RDATA = 2'd2;

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [1:0]    state;
    logic          owner;     // 0 = CPU, 1 = DMA
    logic          lat_we;
    logic          prio;      // port favoured on a tie: 0 = CPU, 1 = DMA
    logic          d_wins;
    logic [DW-1:0] c_rdata_q;
    logic [DW-1:0] d_rdata_q;

    always_comb begin
        d_wins = d_req && (!c_req || prio);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            prio      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            c_count   <= '0;
            d_count   <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (c_req || d_req) begin
                        owner     <= d_wins;
                        lat_we    <= d_wins ? d_we    : c_we;
                        mem_addr  <= d_wins ? d_addr  : c_addr;
                        mem_wdata <= d_wins ? d_wdata : c_wdata;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    prio <= ~owner;
                    if (owner) begin
                        if (d_count != CNT_MAX) d_count <= d_count + 1'b1;
                    end else begin
                        if (c_count != CNT_MAX) c_count <= c_count + 1'b1;
                    end
                    state <= lat_we ? S_IDLE : S_RDATA;
                end
                S_RDATA: begin
                    if (owner) d_rdata_q <= mem_rdata;
                    else       c_rdata_q <= mem_rdata;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_we   = (state == S_ISSUE) && lat_we;
    assign c_gnt    = (state == S_ISSUE) && !owner;
    assign d_gnt    = (state == S_ISSUE) &&  owner;
    // A reset landing in RDATA abandons the read, so rvalid is suppressed in that cycle.
    assign c_rvalid = (state == S_RDATA) && !owner && !rst;
    assign d_rvalid = (state == S_RDATA) &&  owner && !rst;
    assign c_rdata  = c_rvalid ? mem_rdata : c_rdata_q;
    assign d_rdata  = d_rvalid ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural RAM; a CW=4 twin tracks counter saturation.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, d_req, d_we;
    logic [13:0] c_addr, d_addr;
    logic [23:0] c_wdata, d_wdata;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid, mem_we;
    logic [23:0] c_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [13:0] mem_addr;
    logic [15:0] c_count, d_count;

    logic        c_gnt4, c_rvalid4, d_gnt4, d_rvalid4, mem_we4;
    logic [23:0] c_rdata4, d_rdata4, mem_wdata4;
    logic [13:0] mem_addr4;
    logic [3:0]  c_count4, d_count4;

    logic [23:0] ram [0:16383];

    integer checks = 0;
    integer errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    dmem_arbiter #(.AW(14), .DW(24), .CW(16)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .c_count(c_count), .d_count(d_count)
    );

    dmem_arbiter #(.AW(14), .DW(24), .CW(4)) dut4 (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt4), .c_rvalid(c_rvalid4), .c_rdata(c_rdata4),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt4), .d_rvalid(d_rvalid4), .d_rdata(d_rdata4),
        .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata),
        .c_count(c_count4), .d_count(d_count4)
    );

    task automatic do_reset();
        rst = 1'b1; c_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; c_req = 1'b0; d_req = 1'b0;
        c_we = 1'b0; d_we = 1'b0; c_addr = '0; d_addr = '0; c_wdata = '0; d_wdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({c_gnt, d_gnt, c_rvalid, d_rvalid, mem_we} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes got %b want 00000", {c_gnt, d_gnt, c_rvalid, d_rvalid, mem_we});
        end
        checks++;
        if (mem_addr !== 14'h0 || mem_wdata !== 24'h0) begin
            errors++; $display("FAIL reset_mem_bus got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata);
        end
        checks++;
        if (c_count !== 16'd0 || d_count !== 16'd0 || c_rdata !== 24'h0 || d_rdata !== 24'h0) begin
            errors++; $display("FAIL reset_regs got cc=%0d dc=%0d cr=%h dr=%h want all 0", c_count, d_count, c_rdata, d_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (c_gnt !== 1'b0 || d_gnt !== 1'b0) begin
            errors++; $display("FAIL idle_no_gnt got c=%b d=%b want 0/0", c_gnt, d_gnt);
        end
    endtask

    task automatic test_cpu_write_read();
        do_reset();
        c_req = 1'b1; c_we = 1'b1; c_addr = 14'h0010; c_wdata = 24'h123456;
        @(negedge clk);
        checks++;
        if (c_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_we !== 1'b1) begin
            errors++; $display("FAIL wr_issue got c_gnt=%b d_gnt=%b mem_we=%b want 1/0/1", c_gnt, d_gnt, mem_we);
        end
        checks++;
        if (mem_addr !== 14'h0010 || mem_wdata !== 24'h123456) begin
            errors++; $display("FAIL wr_bus got addr=%h wdata=%h want 0010/123456", mem_addr, mem_wdata);
        end
        c_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || c_gnt !== 1'b0) begin
            errors++; $display("FAIL wr_one_clk got mem_we=%b c_gnt=%b want 0/0", mem_we, c_gnt);
        end
        c_req = 1'b1; c_we = 1'b0;
        @(negedge clk);
        checks++;
        if (c_gnt !== 1'b1 || mem_we !== 1'b0) begin
            errors++; $display("FAIL rd_issue got c_gnt=%b mem_we=%b want 1/0", c_gnt, mem_we);
        end
        c_req = 1'b0;
        @(negedge clk);
        checks++;
        if (c_rvalid !== 1'b1 || c_rdata !== 24'h123456 || d_rvalid !== 1'b0) begin
            errors++; $display("FAIL rd_data got rvalid=%b rdata=%h d_rvalid=%b want 1/123456/0", c_rvalid, c_rdata, d_rvalid);
        end
        @(negedge clk);
        checks++;
        if (c_rvalid !== 1'b0 || c_rdata !== 24'h123456 || c_count !== 16'd2) begin
            errors++; $display("FAIL rd_hold got rvalid=%b rdata=%h count=%0d want 0/123456/2", c_rvalid, c_rdata, c_count);
        end
    endtask

    task automatic test_alternate();
        int n;
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 14'h0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0020;
        for (int g = 0; g < 8; g++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(c_gnt || d_gnt) && n < 8);
            checks++;
            if (c_gnt !== ((g % 2) == 0) || d_gnt !== ((g % 2) == 1) || n != ((g == 0) ? 1 : 3)) begin
                errors++; $display("FAIL alt_grant%0d got c=%b d=%b wait=%0d want c=%0d wait=%0d",
                                   g, c_gnt, d_gnt, n, (g % 2) == 0, (g == 0) ? 1 : 3);
            end
        end
        c_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (c_count !== 16'd4 || d_count !== 16'd4) begin
            errors++; $display("FAIL alt_counts got c=%0d d=%0d want 4/4", c_count, d_count);
        end
    endtask

    task automatic test_dma_burst();
        int n;
        do_reset();
        d_we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d_addr  = 14'(14'h0100 + i);
            d_wdata = 24'(24'hA00000 + i * 24'h000111);
            d_req   = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!d_gnt && n < 6);
            checks++;
            if (d_gnt !== 1'b1 || n != ((i == 0) ? 1 : 2) || mem_addr !== d_addr || mem_we !== 1'b1) begin
                errors++; $display("FAIL burst%0d got gnt=%b wait=%0d addr=%h we=%b want 1/%0d/%h/1",
                                   i, d_gnt, n, mem_addr, mem_we, (i == 0) ? 1 : 2, d_addr);
            end
        end
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (d_count !== 16'd8 || c_count !== 16'd0) begin
            errors++; $display("FAIL burst_counts got d=%0d c=%0d want 8/0", d_count, c_count);
        end
        c_req = 1'b1; c_we = 1'b0; c_addr = 14'h0103;
        @(negedge clk);
        c_req = 1'b0;
        @(negedge clk);
        checks++;
        if (c_rvalid !== 1'b1 || c_rdata !== 24'hA00333) begin
            errors++; $display("FAIL burst_readback got rvalid=%b rdata=%h want 1/a00333", c_rvalid, c_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 14'h0010;
        @(negedge clk);
        c_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (c_rvalid !== 1'b0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL mid_rst_rvalid got rvalid=%b mem_we=%b want 0/0", c_rvalid, mem_we);
        end
        @(negedge clk);
        checks++;
        if (c_count !== 16'd0 || c_rvalid !== 1'b0 || c_rdata !== 24'h0) begin
            errors++; $display("FAIL mid_rst_state got count=%0d rvalid=%b rdata=%h want 0/0/0", c_count, c_rvalid, c_rdata);
        end
        rst = 1'b0;
        c_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0020;
        @(negedge clk);
        checks++;
        if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin
            errors++; $display("FAIL mid_rst_prio got c_gnt=%b d_gnt=%b want 1/0", c_gnt, d_gnt);
        end
        c_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_saturate();
        do_reset();
        c_we = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            c_addr = 14'(14'h0300 + k); c_wdata = 24'(k);
            c_req = 1'b1;
            @(negedge clk);
            c_req = 1'b0;
            @(negedge clk);
            if (k == 14 || k == 15 || k == 17) begin
                checks++;
                if (c_count !== 16'(k) || c_count4 !== ((k < 15) ? 4'(k) : 4'd15)) begin
                    errors++; $display("FAIL sat_after%0d got c16=%0d c4=%0d want %0d/%0d",
                                       k, c_count, c_count4, k, (k < 15) ? k : 15);
                end
            end
        end
    endtask

    task automatic test_drop_req();
        int n;
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 14'h0200; d_wdata = 24'h55AA55;
        @(negedge clk);
        d_req = 1'b0;
        checks++;
        if (d_gnt !== 1'b1 || mem_addr !== 14'h0200) begin
            errors++; $display("FAIL drop_issue got gnt=%b addr=%h want 1/0200", d_gnt, mem_addr);
        end
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (d_gnt) n++;
        end
        checks++;
        if (n != 0 || d_count !== 16'd1) begin
            errors++; $display("FAIL drop_single got extra_gnts=%0d count=%0d want 0/1", n, d_count);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write_read();
        test_alternate();
        test_dma_burst();
        test_reset_mid_read();
        test_saturate();
        test_drop_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
